dizy_round_ctrl: RTL and testbench
==================================

Name: dizy_round_ctrl

Overview:
Iterative round sequencer for the DIZY permutation core. It holds the state register and feeds it through the external combinational round function once per cycle, for NUM_ROUNDS cycles. The round function is S-box layer, group mixing and round-constant add, driven by round_idx/round_last. Upstream and downstream use valid/ready handshakes; one permutation is in flight at a time.

Parameters:
SIZE_STATE, `SIZE_STATE (global DIZY macro), state width in bits; must be a multiple of 8.
NUM_ROUNDS, 8, rounds per permutation; legal range 1..255.
ROUND_W, $clog2(NUM_ROUNDS) with a minimum of 1, width of round_idx; derived, not to be overridden.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input state offered
in_ready  out  1  controller can accept a state
in_state  in  SIZE_STATE  state to permute
out_valid  out  1  permuted state available
out_ready  in  1  consumer accepts out_state
out_state  out  SIZE_STATE  permuted state, equals state register
rf_in  out  SIZE_STATE  to round function, equals state register
rf_out  in  SIZE_STATE  round function result (combinational from rf_in)
round_idx  out  ROUND_W  current round number, 0..NUM_ROUNDS-1
round_last  out  1  high when round_idx == NUM_ROUNDS-1 in RUN
busy  out  1  high in RUN or DONE

Behaviour:
- FSM states: IDLE, RUN, DONE. Registered state, registered round counter.
- Reset values: FSM=IDLE, state register=0, round_idx=0, out_valid=0, busy=0, round_last=0. in_ready=1 in the first cycle after reset.
- IDLE: in_ready=1. On in_valid, load state<=in_state, round_idx<=0, go to RUN.
- RUN: in_ready=0, out_valid=0. Each cycle state<=rf_out. If round_last, then round_idx<=0 and go to DONE; otherwise round_idx<=round_idx+1.
- DONE: out_valid=1 and out_state stable until accepted. On out_ready, go to IDLE; state register holds its value and is not cleared.
- Latency: accept edge to out_valid = NUM_ROUNDS+1 cycles. With NUM_ROUNDS=1, RUN lasts exactly one cycle with round_last=1.
- Outside RUN, round_last=0 and round_idx=0. rf_in always mirrors the state register.
- in_valid in RUN/DONE is ignored (in_ready=0); in_state need not be stable then.
- out_ready outside DONE has no effect.
- rst asserted in any state, including mid-RUN, returns to reset values next edge; the partial permutation is discarded and out_valid never rises for it.
- round_idx never exceeds NUM_ROUNDS-1; no wrap beyond that.

Optional Feature:
Macro DIZY_ROUND_CTRL_BACK2BACK_EN.
- Defined: in DONE, in_ready = out_ready. If out_ready && in_valid in the same cycle, the new in_state is loaded, round_idx<=0, and the FSM goes directly to RUN, skipping IDLE. Throughput becomes one permutation per NUM_ROUNDS+1 cycles.
- Undefined: in DONE, in_ready=0. A new permutation starts at least one IDLE cycle after the handshake, giving NUM_ROUNDS+2 cycles per permutation.

Test Plan:
- Stub the round function as rf_out = rf_in + round_idx + 1, with NUM_ROUNDS=8. Load 0x0, then out_state=36 (0x24), out_valid rises exactly 9 cycles after the accept edge, and round_last is high only at round_idx=7.
- Reset check: immediately after rst, out_valid=0, busy=0, in_ready=1, round_idx=0.
- Backpressure: hold out_ready=0 for 20 cycles in DONE. out_valid stays 1, out_state stays stable, in_ready stays 0. Then pulse out_ready for 1 cycle and the FSM reaches IDLE next cycle.
- Mid-run reset: assert rst at round_idx=4. Next cycle the FSM is IDLE with round_idx=0, and out_valid stays 0 for 20 following cycles.
- NUM_ROUNDS=1 with the same stub: load 0x5, then out_state=0x6 with out_valid 2 cycles after accept.
- With DIZY_ROUND_CTRL_BACK2BACK_EN and in_valid held high with values 0x0 and 0x100: two outputs spaced exactly 9 cycles apart, with no IDLE cycle between them. Without the macro the spacing is 10 cycles.

Source files
------------

// File: rtl/dizy_round_ctrl.sv
// Iterative DIZY round sequencer: loads a state, runs it through the external round function once per cycle.
// Latency: out_valid is high NUM_ROUNDS+1 cycles after the handshake cycle; one permutation in flight.
// Backpressure: holds out_state/out_valid in DONE until out_ready; in_ready is low while busy.
// Optional macro DIZY_ROUND_CTRL_BACK2BACK_EN: DONE can accept the next state in the same cycle as out_ready.

`ifndef SIZE_STATE
`define SIZE_STATE 64
`endif

module dizy_round_ctrl #(
    parameter int SIZE_STATE = `SIZE_STATE,
    parameter int NUM_ROUNDS = 8,
    localparam int ROUND_W   = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIZE_STATE-1:0] in_state,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIZE_STATE-1:0] out_state,
    output logic [SIZE_STATE-1:0] rf_in,
    input  logic [SIZE_STATE-1:0] rf_out,
    output logic [ROUND_W-1:0]    round_idx,
    output logic                  round_last,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

    fsm_e                  fsm_q, fsm_d;
    logic [SIZE_STATE-1:0] state_q, state_d;
    logic [ROUND_W-1:0]    round_q, round_d;

    // The state register is the single source for both the round function and the output.
    assign rf_in     = state_q;
    assign out_state = state_q;
    assign round_idx = round_q;

    // Register FSM, data state and round counter; reset discards any partial permutation.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    // Next-state, next-data and handshake outputs.
    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        round_d    = round_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        round_last = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = in_state;
                    round_d = '0;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                busy       = 1'b1;
                round_last = (round_q == LAST_ROUND);
                state_d    = rf_out;
                if (round_q == LAST_ROUND) begin
                    // Counter returns to zero so round_idx reads 0 outside RUN.
                    round_d = '0;
                    fsm_d   = DONE;
                end else begin
                    round_d = round_q + ROUND_W'(1);
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
`ifdef DIZY_ROUND_CTRL_BACK2BACK_EN
                // Accepting the next state in the same cycle as the output handshake skips IDLE.
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        state_d = in_state;
                        round_d = '0;
                        fsm_d   = RUN;
                    end else begin
                        fsm_d = IDLE;
                    end
                end
`else
                // State register keeps the result after the handshake; only the FSM moves.
                if (out_ready) begin
                    fsm_d = IDLE;
                end
`endif
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dizy_round_ctrl.sv
// Directed bench for dizy_round_ctrl with the stub round function rf_out = rf_in + round_idx + 1.
// Instance a uses NUM_ROUNDS=8, instance b uses NUM_ROUNDS=1; both share clock and reset.
// Expected values are hand-computed: 0 -> 36 (sum 1..8), 0x100 -> 0x124, 5 -> 6.

module tb_dizy_round_ctrl;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic         a_in_valid = 1'b0;
    logic         a_in_ready;
    logic [W-1:0] a_in_state = '0;
    logic         a_out_valid;
    logic         a_out_ready = 1'b0;
    logic [W-1:0] a_out_state;
    logic [W-1:0] a_rf_in;
    logic [W-1:0] a_rf_out;
    logic [2:0]   a_round_idx;
    logic         a_round_last;
    logic         a_busy;

    logic         b_in_valid = 1'b0;
    logic         b_in_ready;
    logic [W-1:0] b_in_state = '0;
    logic         b_out_valid;
    logic         b_out_ready = 1'b0;
    logic [W-1:0] b_out_state;
    logic [W-1:0] b_rf_in;
    logic [W-1:0] b_rf_out;
    logic [0:0]   b_round_idx;
    logic         b_round_last;
    logic         b_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign a_rf_out = a_rf_in + W'(a_round_idx) + W'(1);
    assign b_rf_out = b_rf_in + W'(b_round_idx) + W'(1);

    dizy_round_ctrl #(.SIZE_STATE(W), .NUM_ROUNDS(8)) u_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_state   (a_in_state),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_state  (a_out_state),
        .rf_in      (a_rf_in),
        .rf_out     (a_rf_out),
        .round_idx  (a_round_idx),
        .round_last (a_round_last),
        .busy       (a_busy)
    );

    dizy_round_ctrl #(.SIZE_STATE(W), .NUM_ROUNDS(1)) u_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_state   (b_in_state),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_state  (b_out_state),
        .rf_in      (b_rf_in),
        .rf_out     (b_rf_out),
        .round_idx  (b_round_idx),
        .round_last (b_round_last),
        .busy       (b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    initial begin
        int cnt;
        int t1;
        int t2;
        int idle_gap;
        int cyc;
        int rises;
        logic prev;
`ifdef DIZY_ROUND_CTRL_BACK2BACK_EN
        int exp_space = 9;
        int exp_gap   = 0;
`else
        int exp_space = 10;
        int exp_gap   = 1;
`endif

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);
        chk("rst_round_idx", 64'(a_round_idx), 64'd0);
        chk("rst_round_last", 64'(a_round_last), 64'd0);
        chk("rst_out_state", 64'(a_out_state), 64'd0);
        chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);

        // Basic permutation of 0 with round-by-round index/last checks
        a_in_state = 32'h0;
        a_in_valid = 1'b1;
        chk("run_accept_ready", 64'(a_in_ready), 64'd1);
        cnt = 0;
        do begin
            @(negedge clk);
            a_in_valid = 1'b0;
            a_in_state = 32'hFFFF_FFFF;
            cnt++;
            if (cnt <= 8) begin
                chk("run_round_idx", 64'(a_round_idx), 64'(cnt - 1));
                chk("run_round_last", 64'(a_round_last), (cnt == 8) ? 64'd1 : 64'd0);
                chk("run_in_ready", 64'(a_in_ready), 64'd0);
            end
        end while (!a_out_valid && cnt < 40);
        chk("run_latency", 64'(cnt), 64'd9);
        chk("run_result", 64'(a_out_state), 64'd36);
        chk("done_round_idx", 64'(a_round_idx), 64'd0);
        chk("done_round_last", 64'(a_round_last), 64'd0);

        // Backpressure in DONE, with ignored input offers
        a_in_valid = 1'b1;
        a_in_state = 32'hDEAD;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(a_out_valid), 64'd1);
            chk("bp_out_state", 64'(a_out_state), 64'd36);
            chk("bp_in_ready", 64'(a_in_ready), 64'd0);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        chk("pulse_idle_busy", 64'(a_busy), 64'd0);
        chk("pulse_idle_ready", 64'(a_in_ready), 64'd1);
        chk("pulse_idle_valid", 64'(a_out_valid), 64'd0);
        chk("pulse_state_held", 64'(a_out_state), 64'd36);
        @(negedge clk);
        chk("outready_idle_noeffect", 64'(a_busy), 64'd0);

        // Mid-run reset at round 4
        a_in_state = 32'h10;
        a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        cnt = 0;
        while (a_round_idx != 3'd4 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("mid_reach_idx4", 64'(a_round_idx), 64'd4);
        chk("mid_busy_before", 64'(a_busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 64'(a_busy), 64'd0);
        chk("mid_rst_round_idx", 64'(a_round_idx), 64'd0);
        chk("mid_rst_in_ready", 64'(a_in_ready), 64'd1);
        chk("mid_rst_state", 64'(a_out_state), 64'd0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_out_valid) cnt++;
        end
        chk("mid_no_out_valid", 64'(cnt), 64'd0);

        // NUM_ROUNDS=1 instance
        b_in_state = 32'h5;
        b_in_valid = 1'b1;
        chk("b_accept_ready", 64'(b_in_ready), 64'd1);
        @(negedge clk);
        b_in_valid = 1'b0;
        chk("b_run_last", 64'(b_round_last), 64'd1);
        chk("b_run_idx", 64'(b_round_idx), 64'd0);
        chk("b_run_valid", 64'(b_out_valid), 64'd0);
        @(negedge clk);
        chk("b_done_valid", 64'(b_out_valid), 64'd1);
        chk("b_done_state", 64'(b_out_state), 64'd6);
        chk("b_done_last", 64'(b_round_last), 64'd0);
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        chk("b_back_idle", 64'(b_busy), 64'd0);

        // Back-to-back spacing with in_valid and out_ready held high
        a_in_state  = 32'h0;
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        prev     = a_out_valid;
        rises    = 0;
        t1       = 0;
        t2       = 0;
        idle_gap = 0;
        cyc      = 0;
        while (rises < 2 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (rises == 1 && !a_busy) idle_gap++;
            if (a_out_valid && !prev) begin
                rises++;
                if (rises == 1) begin
                    t1 = cyc;
                    chk("b2b_first_state", 64'(a_out_state), 64'd36);
                    a_in_state = 32'h100;
                end else begin
                    t2 = cyc;
                    chk("b2b_second_state", 64'(a_out_state), 64'h124);
                    a_in_valid = 1'b0;
                end
            end
            prev = a_out_valid;
        end
        chk("b2b_two_outputs", 64'(rises), 64'd2);
        chk("b2b_spacing", 64'(t2 - t1), 64'(exp_space));
        chk("b2b_idle_cycles", 64'(idle_gap), 64'(exp_gap));
        @(negedge clk);
        a_out_ready = 1'b0;
        chk("b2b_final_idle", 64'(a_busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
